fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-port arbiter that shares the single write port of the test FIFO between N_REQ producers. It sits between the producer-side drivers and the FIFO write modport. Each grant is a burst of at most MAX_BURST words, so no producer can starve the others. FIFO full is honoured without loss or duplication.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 8, data width, equal to the FIFO data width
- MAX_BURST, 4, maximum words accepted per grant (≥1)
- clkrstn (clock)  input  1  clock from clkrstn, rising-edge
- clkrstn (reset)  input  1  reset from clkrstn, asynchronous, active-high
- req  input  N_REQ  per-requester "word available", level
- req_data  input  N_REQ×DW  per-requester write data, valid while req[i]=1
- gnt  output  N_REQ  one-hot accept pulse: word of requester i consumed this cycle
- owner  output  $clog2(N_REQ)  index of current burst owner (valid when busy=1)
- busy  output  1  burst in progress
- fifo_full  input  1  FIFO full flag
- fifo_wr_en  output  1  FIFO write enable
- fifo_wr_data  output  DW  FIFO write data

## Operation
- States: IDLE, BURST.
- IDLE: busy=0, fifo_wr_en=0, gnt=0. If any req bit is set, select the first set bit searching upward (wrapping) from rr_ptr+1. Latch it into owner, clear burst_cnt and go to BURST next cycle. If no req bit is set, stay in IDLE.
- BURST transfer condition: req[owner]=1 and fifo_full=0.
  - When it holds: fifo_wr_en=1, fifo_wr_data=req_data[owner], gnt[owner]=1, burst_cnt+1.
  - When fifo_full=1: no write, no gnt, count held, state held (stall).
- BURST exit to IDLE on the clock edge after either:
  - a transfer that makes burst_cnt reach MAX_BURST, or
  - a cycle with req[owner]=0. No transfer happens in that cycle.
- On exit, rr_ptr is set to owner.
- A non-owner req never produces gnt. Requesters hold req/req_data until they see gnt, then present their next word or drop req.
- At most one gnt bit is ever set; gnt ≡ fifo_wr_en at the owner position.
- Reset values: state IDLE, rr_ptr=N_REQ-1 (so requester 0 wins first), owner=0, burst_cnt=0, busy=0, gnt=0, fifo_wr_en=0.
- fifo_wr_data is 0 when fifo_wr_en=0.
- Reset asserted mid-burst: all state returns to reset values immediately. A word not yet granted is not written.

## Timing
- fifo_wr_en, fifo_wr_data and gnt are combinational from state, owner, req[owner] and fifo_full. There are no other combinational paths.
- Arbitration overhead is 1 IDLE cycle per burst, so throughput is at most MAX_BURST/(MAX_BURST+1) words/cycle with continuous requesters.
- First write appears 1 cycle after req rises in IDLE.
- fifo_full must reflect FIFO state in the same cycle. A write is never issued while fifo_full=1.
- fifo_full rising during a burst: the stall starts that same cycle. The burst resumes in the first cycle with fifo_full=0 without re-arbitration.

## Structure
- Shared package fifo_pkg holds:
  - arb_state_e (IDLE, BURST)
  - the default DW
  - function rr_pick(req, ptr), returning a round-robin index plus a found flag
- One sub-module, rr_select: a purely combinational rotate-priority encoder (req, ptr → index, found). It is reused by later arbiters.
- Everything else is in fifo_wr_arb (state, owner, rr_ptr, burst_cnt).

## Test plan
- Single requester: req[2]=1 continuously, data 0x10.. incrementing on gnt, FIFO never full.
  - Required: IDLE, then writes 0x10–0x13, then IDLE, then writes 0x14–0x17.
  - gnt[2] pulses exactly 4 times per burst.
- All four requesting continuously after reset.
  - Required: owner sequence 0,1,2,3,0.
  - Each burst is 4 writes, separated by 1 idle cycle.
- Early release: req[1] drops after 2 grants.
  - Required: burst ends with 2 writes.
  - The next owner is the next set bit above 1.
- Full stall: fifo_full=1 for 3 cycles after the 2nd write of a burst.
  - Required: fifo_wr_en=0 and gnt=0 during those 3 cycles.
  - Words 3–4 are then written with no loss or duplicate, and the burst still totals 4.
- Reset mid-burst: assert reset after the 1st write of owner 3.
  - Required: outputs go to 0 immediately and busy=0.
  - After release with all four requesting, owner 0 is granted first.
- Scoreboard every test: the FIFO contents must equal, per requester, the exact sequence of gnt-accepted words in order. A write while fifo_full=1 fails the test.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: arbiter state encoding, default data width and
// the round-robin pick function used by rr_select and later arbiters.
package fifo_pkg;

   localparam int unsigned DefaultDw = 8;
   localparam int unsigned MaxReq    = 8;
   localparam int unsigned MaxIdxW   = 3;

   typedef enum logic {StIdle, StBurst} arb_state_e;

   typedef struct packed {
      logic               found;
      logic [MaxIdxW-1:0] idx;
   } rr_pick_t;

   // First set bit of req[n-1:0] searching upward from ptr+1, wrapping at n.
   function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  req,
                                        input logic [MaxIdxW-1:0] ptr,
                                        input int unsigned        n);
      rr_pick_t    res;
      int unsigned j;
      res = '0;
      for (int unsigned k = 1; k <= MaxReq; k++) begin
         j = (32'(ptr) + k) % n;
         if (k <= n && !res.found && req[j]) begin
            res.found = 1'b1;
            res.idx   = MaxIdxW'(j);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational rotate-priority encoder: lowest set req bit above ptr, wrapping.
module rr_select
   import fifo_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] index,
   output logic                     found
);

   rr_pick_t pick;

   always_comb begin
      pick  = rr_pick(MaxReq'(req), MaxIdxW'(ptr), N_REQ);
      index = pick.idx[$clog2(N_REQ)-1:0];
      found = pick.found;
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// granting bursts of at most MAX_BURST words and stalling on fifo_full.
module fifo_wr_arb
   import fifo_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DW        = DefaultDw,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                     clkrstn_clk,
   input  logic                     clkrstn_rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*DW-1:0]      req_data,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [DW-1:0]            fifo_wr_data
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic [IW-1:0] sel_idx;
   logic          sel_found;
   logic          xfer;

   rr_select #(
      .N_REQ(N_REQ)
   ) u_rr_select (
      .req  (req),
      .ptr  (rr_ptr_q),
      .index(sel_idx),
      .found(sel_found)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      xfer        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               owner_d     = sel_idx;
               burst_cnt_d = '0;
               state_d     = StBurst;
            end
         end
         StBurst: begin
            xfer = req[owner_q] && !fifo_full;
            if (xfer) begin
               burst_cnt_d = burst_cnt_q + CW'(1);
               if (burst_cnt_d == CW'(MAX_BURST)) begin
                  state_d  = StIdle;
                  rr_ptr_d = owner_q;
               end
            end else if (!req[owner_q]) begin
               // Owner released early; a full-only stall keeps the burst.
               state_d  = StIdle;
               rr_ptr_d = owner_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clkrstn_clk or posedge clkrstn_rst) begin
      if (clkrstn_rst) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         rr_ptr_q    <= IW'(N_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign busy         = (state_q == StBurst);
   assign owner        = owner_q;
   assign fifo_wr_en   = xfer;
   assign gnt          = xfer ? (N_REQ'(1) << owner_q) : '0;
   assign fifo_wr_data = xfer ? req_data[owner_q*DW +: DW] : '0;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized traffic
// against a behavioural round-robin burst model and a FIFO scoreboard.
module tb_fifo_wr_arb;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic [N-1:0]      gnt;
   logic [1:0]        owner;
   logic              busy;
   logic              fifo_full = 1'b0;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_wr_data;

   int n_checks = 0;
   int n_pass   = 0;

   // Producer word counters and behavioural arbiter model.
   logic [DW-1:0] dat [N];
   bit            m_busy;
   int            m_owner, m_cnt, m_ptr;
   logic [N-1:0]  m_last_gnt;

   // Per-test logs: write-enable per cycle, FIFO contents and their sources.
   bit            cyc_wr [$];
   logic [DW-1:0] fifo_q [$];
   int            fifo_src [$];
   int            gnt_total;

   always #5 clk = ~clk;

   fifo_wr_arb #(
      .N_REQ    (N),
      .DW       (DW),
      .MAX_BURST(MB)
   ) dut (
      .clkrstn_clk (clk),
      .clkrstn_rst (rst),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .owner       (owner),
      .busy        (busy),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wr_data(fifo_wr_data)
   );

   task automatic clear_logs();
      cyc_wr.delete();
      fifo_q.delete();
      fifo_src.delete();
      gnt_total = 0;
   endtask

   task automatic do_reset();
      req       = '0;
      fifo_full = 1'b0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst        = 1'b0;
      m_busy     = 0;
      m_owner    = 0;
      m_cnt      = 0;
      m_ptr      = N - 1;
      m_last_gnt = '0;
      clear_logs();
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance.
   task automatic step(input logic [N-1:0] r, input bit full);
      bit            exp_wr;
      logic [N-1:0]  exp_gnt;
      logic [DW-1:0] exp_data;
      bit            found;
      int            j;
      req       = r;
      fifo_full = full;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
      #1;
      exp_wr   = m_busy && r[m_owner] && !full;
      exp_gnt  = exp_wr ? (N'(1) << m_owner) : '0;
      exp_data = exp_wr ? dat[m_owner] : '0;
      n_checks++;
      if (fifo_wr_en !== exp_wr)
         $display("FAIL wr_en t=%0t got %b want %b", $time, fifo_wr_en, exp_wr);
      else n_pass++;
      n_checks++;
      if (gnt !== exp_gnt)
         $display("FAIL gnt t=%0t got %b want %b", $time, gnt, exp_gnt);
      else n_pass++;
      n_checks++;
      if (fifo_wr_data !== exp_data)
         $display("FAIL wr_data t=%0t got %h want %h", $time, fifo_wr_data, exp_data);
      else n_pass++;
      n_checks++;
      if (busy !== m_busy)
         $display("FAIL busy t=%0t got %b want %b", $time, busy, m_busy);
      else n_pass++;
      if (m_busy) begin
         n_checks++;
         if (int'(owner) !== m_owner)
            $display("FAIL owner t=%0t got %0d want %0d", $time, owner, m_owner);
         else n_pass++;
      end
      n_checks++;
      if (fifo_wr_en === 1'b1 && full)
         $display("FAIL write_while_full t=%0t got wr_en=1 want 0", $time);
      else n_pass++;
      cyc_wr.push_back(fifo_wr_en === 1'b1);
      if (fifo_wr_en === 1'b1 && !full) begin
         fifo_q.push_back(fifo_wr_data);
         fifo_src.push_back(int'(owner));
      end
      gnt_total += $countones(gnt);
      m_last_gnt = exp_gnt;
      if (!m_busy) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            j = (m_ptr + k) % N;
            if (!found && r[j]) begin
               found   = 1;
               m_owner = j;
            end
         end
         if (found) begin
            m_busy = 1;
            m_cnt  = 0;
         end
      end else if (exp_wr) begin
         dat[m_owner] = dat[m_owner] + 1'b1;
         m_cnt++;
         if (m_cnt == MB) begin
            m_busy = 0;
            m_ptr  = m_owner;
         end
      end else if (!r[m_owner]) begin
         m_busy = 0;
         m_ptr  = m_owner;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '1;
      #2;
      n_checks++;
      if (gnt !== '0) $display("FAIL reset_gnt got %b want 0", gnt); else n_pass++;
      n_checks++;
      if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", fifo_wr_en);
      else n_pass++;
      n_checks++;
      if (fifo_wr_data !== '0) $display("FAIL reset_wr_data got %h want 0", fifo_wr_data);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++;
      if (owner !== '0) $display("FAIL reset_owner got %0d want 0", owner); else n_pass++;
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      dat[2] = 8'h10;
      for (int c = 0; c < 10; c++) step(4'b0100, 1'b0);
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (cyc_wr[c] != ((c % 5) != 0))
            $display("FAIL single_pattern c=%0d got %b want %b", c, cyc_wr[c], (c % 5) != 0);
         else n_pass++;
      end
      n_checks++;
      if (fifo_q.size() != 8) $display("FAIL single_count got %0d want 8", fifo_q.size());
      else begin
         n_pass++;
         for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (fifo_q[k] !== DW'(8'h10 + k))
               $display("FAIL single_data k=%0d got %h want %h", k, fifo_q[k], 8'h10 + k);
            else n_pass++;
         end
      end
      n_checks++;
      if (gnt_total != 8) $display("FAIL single_gnts got %0d want 8", gnt_total);
      else n_pass++;
   endtask

   task automatic test_all();
      do_reset();
      for (int c = 0; c < 25; c++) step(4'b1111, 1'b0);
      for (int c = 0; c < 25; c++) begin
         n_checks++;
         if (cyc_wr[c] != ((c % 5) != 0))
            $display("FAIL all_pattern c=%0d got %b want %b", c, cyc_wr[c], (c % 5) != 0);
         else n_pass++;
      end
      n_checks++;
      if (fifo_src.size() != 20) $display("FAIL all_count got %0d want 20", fifo_src.size());
      else begin
         n_pass++;
         for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (fifo_src[k] != (k / 4) % 4)
               $display("FAIL all_owner k=%0d got %0d want %0d", k, fifo_src[k], (k / 4) % 4);
            else n_pass++;
         end
      end
   endtask

   task automatic test_early();
      int exp_src [6] = '{1, 1, 3, 3, 3, 3};
      do_reset();
      for (int c = 0; c < 10; c++) step((c < 3) ? 4'b1010 : 4'b1000, 1'b0);
      n_checks++;
      if (fifo_src.size() != 6) $display("FAIL early_count got %0d want 6", fifo_src.size());
      else begin
         n_pass++;
         for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (fifo_src[k] != exp_src[k])
               $display("FAIL early_owner k=%0d got %0d want %0d", k, fifo_src[k], exp_src[k]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_stall();
      bit            exp_pat [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
      logic [DW-1:0] base;
      do_reset();
      base = 8'hA0;
      dat[0] = base;
      for (int c = 0; c < 9; c++) step(4'b0001, c >= 3 && c <= 5);
      for (int c = 0; c < 9; c++) begin
         n_checks++;
         if (cyc_wr[c] != exp_pat[c])
            $display("FAIL stall_pattern c=%0d got %b want %b", c, cyc_wr[c], exp_pat[c]);
         else n_pass++;
      end
      n_checks++;
      if (fifo_q.size() != 4) $display("FAIL stall_count got %0d want 4", fifo_q.size());
      else begin
         n_pass++;
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (fifo_q[k] !== DW'(base + k))
               $display("FAIL stall_data k=%0d got %h want %h", k, fifo_q[k], base + k);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 17; c++) step(4'b1111, 1'b0);
      n_checks++;
      if (fifo_src.size() != 13 || fifo_src[fifo_src.size()-1] != 3)
         $display("FAIL mid_setup got %0d writes want 13 ending with owner 3", fifo_src.size());
      else n_pass++;
      req = 4'b1111;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (fifo_wr_en !== 1'b0 || gnt !== '0 || fifo_wr_data !== '0)
         $display("FAIL mid_outputs got wr_en=%b gnt=%b data=%h want all 0",
                  fifo_wr_en, gnt, fifo_wr_data);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || owner !== '0)
         $display("FAIL mid_state got busy=%b owner=%0d want 0/0", busy, owner);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst        = 1'b0;
      m_busy     = 0;
      m_owner    = 0;
      m_cnt      = 0;
      m_ptr      = N - 1;
      clear_logs();
      for (int c = 0; c < 5; c++) step(4'b1111, 1'b0);
      n_checks++;
      if (fifo_src.size() != 4 || fifo_src[0] != 0)
         $display("FAIL mid_restart got %0d writes want 4 from owner 0", fifo_src.size());
      else n_pass++;
   endtask

   task automatic test_random();
      logic [N-1:0] r = '0;
      bit           full;
      do_reset();
      for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
      for (int c = 0; c < 600; c++) begin
         // Producers hold req until granted, then may drop or present the next word.
         for (int i = 0; i < N; i++)
            if (!r[i] || m_last_gnt[i]) r[i] = ($urandom_range(3) != 0);
         full = ($urandom_range(3) == 0);
         step(r, full);
      end
      n_checks++;
      if (fifo_q.size() != gnt_total)
         $display("FAIL random_scoreboard got %0d words want %0d", fifo_q.size(), gnt_total);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < N; i++) dat[i] = '0;
      test_reset();
      test_single();
      test_all();
      test_early();
      test_stall();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
